// File: rtl/sys_arr_pkg.sv
// sys_arr_pkg: shared types and default sizes for the GSAU control path
package sys_arr_pkg;
  typedef enum logic [1:0] {WEIGHT, ACT, ACT_PSUM, RSVD} gsau_mode_t;
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, ISSUE} gsau_state_t;
  localparam int GSAU_DATA_W = 512;
  localparam int GSAU_TAG_W = 8;
  localparam int GSAU_DEPTH = 4;
endpackage

// File: rtl/gsau_sync_fifo.sv
// gsau_sync_fifo: synchronous FIFO with wrap-bit pointers and a combinational head
module gsau_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = wr_ptr == rd_ptr;
  assign full = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign head = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/gsau_ctrl_v2.sv
// gsau_ctrl_v2: GSAU instruction sequencer with tag tracking and result buffering
module gsau_ctrl_v2
  import sys_arr_pkg::*;
#(
  parameter int DATA_W = GSAU_DATA_W,
  parameter int TAG_W = GSAU_TAG_W,
  parameter int DEPTH = GSAU_DEPTH
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              sb_nvalid,
  input  logic [TAG_W-1:0]  sb_nvdst,
  input  logic [1:0]        sb_nmode,
  output logic              sb_ready,
  output logic              sb_valid,
  output logic [TAG_W-1:0]  sb_vdst,
  input  logic [DATA_W-1:0] veg_vdata,
  input  logic              veg_valid,
  output logic              veg_ready,
  output logic [DATA_W-1:0] sa_array_in,
  output logic [DATA_W-1:0] sa_array_in_partials,
  output logic              sa_input_en,
  output logic              sa_weight_en,
  output logic              sa_partial_en,
  input  logic              sa_fifo_has_space,
  input  logic [DATA_W-1:0] sa_array_output,
  input  logic              sa_out_en,
  output logic [DATA_W-1:0] wb_psum,
  output logic [TAG_W-1:0]  wb_wbdst,
  output logic              wb_valid,
  input  logic              wb_output_ready,
  output logic              err
);
  localparam int CW = $clog2(DEPTH) + 1;
  gsau_state_t state, state_n;
  gsau_mode_t mode_q;
  logic [TAG_W-1:0] vdst_q, tag_head;
  logic [DATA_W-1:0] act_q, psum_q;
  logic [CW-1:0] inflight;
  logic can_issue, issue, act_issue, wb_xfer, sb_xfer, res_push;
  logic tag_full, tag_empty, res_full, res_empty;
  logic [TAG_W+DATA_W-1:0] res_head;
  always_comb begin
    sb_ready = state == IDLE;
    veg_ready = state == BEAT0 || state == BEAT1;
    sb_xfer = sb_nvalid && sb_ready;
    can_issue = sa_fifo_has_space && (mode_q == WEIGHT ? inflight == '0 : inflight < CW'(DEPTH) && !tag_full);
    issue = state == ISSUE && can_issue;
    act_issue = issue && mode_q != WEIGHT;
    sa_weight_en = issue && mode_q == WEIGHT;
    sa_input_en = act_issue;
    sa_partial_en = act_issue && mode_q == ACT_PSUM;
    sa_array_in = act_q;
    sa_array_in_partials = psum_q;
    res_push = sa_out_en && !tag_empty && !res_full;
    wb_valid = !res_empty;
    wb_psum = res_empty ? '0 : res_head[DATA_W-1:0];
    wb_wbdst = res_empty ? '0 : res_head[TAG_W+DATA_W-1 -: TAG_W];
    wb_xfer = wb_valid && wb_output_ready;
    sb_valid = wb_xfer;
    sb_vdst = wb_xfer ? wb_wbdst : '0;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (sb_nvalid) state_n = BEAT0;
      BEAT0: if (veg_valid) state_n = mode_q == ACT_PSUM ? BEAT1 : ISSUE;
      BEAT1: if (veg_valid) state_n = ISSUE;
      default: if (issue) state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state <= IDLE;
      mode_q <= WEIGHT;
      vdst_q <= '0;
      act_q <= '0;
      psum_q <= '0;
      inflight <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      if (sb_xfer) begin
        vdst_q <= sb_nvdst;
        mode_q <= sb_nmode == 2'd3 ? ACT : gsau_mode_t'(sb_nmode);
      end
      if (state == BEAT0 && veg_valid) act_q <= veg_vdata;
      if (state == BEAT1 && veg_valid) psum_q <= veg_vdata;
      inflight <= inflight + CW'(act_issue) - CW'(wb_xfer);
      if ((sa_out_en && tag_empty) || (sb_xfer && sb_nmode == 2'd3)) err <= 1'b1;
    end
  gsau_sync_fifo #(.WIDTH(TAG_W), .DEPTH(DEPTH)) u_tag_fifo (
    .clk(CLK), .rst_n(nRST), .push(act_issue), .pop(sa_out_en), .din(vdst_q),
    .full(tag_full), .empty(tag_empty), .head(tag_head)
  );
  gsau_sync_fifo #(.WIDTH(TAG_W + DATA_W), .DEPTH(DEPTH)) u_res_fifo (
    .clk(CLK), .rst_n(nRST), .push(res_push), .pop(wb_xfer), .din({tag_head, sa_array_output}),
    .full(res_full), .empty(res_empty), .head(res_head)
  );
endmodule

// File: tb/tb_gsau_ctrl_v2.sv
// tb_gsau_ctrl_v2: directed scenario tests for gsau_ctrl_v2
module tb_gsau_ctrl_v2;
  localparam int DW = 512;
  localparam int TW = 8;
  localparam logic [DW-1:0] PA = {64{8'hAA}};
  localparam logic [DW-1:0] PB = {64{8'hBB}};
  localparam logic [DW-1:0] PC = {64{8'hCC}};
  localparam logic [DW-1:0] P11 = {64{8'h11}};
  logic CLK = 0, nRST = 0;
  logic sb_nvalid = 0, veg_valid = 0, sa_out_en = 0, wb_output_ready = 0, sa_fifo_has_space = 1;
  logic [TW-1:0] sb_nvdst = 0;
  logic [1:0] sb_nmode = 0;
  logic [DW-1:0] veg_vdata = 0, sa_array_output = 0;
  logic sb_ready, sb_valid, veg_ready, sa_input_en, sa_weight_en, sa_partial_en, wb_valid, err;
  logic [TW-1:0] sb_vdst, wb_wbdst;
  logic [DW-1:0] sa_array_in, sa_array_in_partials, wb_psum;
  int passed = 0, total = 0;

  gsau_ctrl_v2 dut (
    .CLK(CLK), .nRST(nRST), .sb_nvalid(sb_nvalid), .sb_nvdst(sb_nvdst), .sb_nmode(sb_nmode),
    .sb_ready(sb_ready), .sb_valid(sb_valid), .sb_vdst(sb_vdst), .veg_vdata(veg_vdata),
    .veg_valid(veg_valid), .veg_ready(veg_ready), .sa_array_in(sa_array_in),
    .sa_array_in_partials(sa_array_in_partials), .sa_input_en(sa_input_en),
    .sa_weight_en(sa_weight_en), .sa_partial_en(sa_partial_en), .sa_fifo_has_space(sa_fifo_has_space),
    .sa_array_output(sa_array_output), .sa_out_en(sa_out_en), .wb_psum(wb_psum), .wb_wbdst(wb_wbdst),
    .wb_valid(wb_valid), .wb_output_ready(wb_output_ready), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [1:0] m, input logic [TW-1:0] t, input logic [DW-1:0] a, input logic [DW-1:0] b);
    sb_nvalid = 1; sb_nmode = m; sb_nvdst = t;
    #1;
    for (int i = 0; i < 40 && !sb_ready; i++) step;
    if (!sb_ready) begin total++; $display("FAIL send_timeout: sb_ready got 0 want 1"); end
    step;
    sb_nvalid = 0; veg_valid = 1; veg_vdata = a;
    step;
    if (m == 2'd2) begin veg_vdata = b; step; end
    veg_valid = 0;
    #1;
  endtask

  task automatic ret(input logic [DW-1:0] d);
    sa_array_output = d; sa_out_en = 1;
    step;
    sa_out_en = 0;
  endtask

  task automatic drain;
    wb_output_ready = 1;
    #1;
    for (int i = 0; i < 20 && wb_valid; i++) step;
    wb_output_ready = 0;
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    total++; if (sb_ready !== 1'b1) $display("FAIL %s sb_ready: got %b want 1", tag, sb_ready); else passed++;
    total++; if (veg_ready !== 1'b0) $display("FAIL %s veg_ready: got %b want 0", tag, veg_ready); else passed++;
    total++; if ({sa_input_en, sa_weight_en, sa_partial_en} !== 3'b000) $display("FAIL %s strobes: got %b want 000", tag, {sa_input_en, sa_weight_en, sa_partial_en}); else passed++;
    total++; if (sa_array_in !== '0 || sa_array_in_partials !== '0) $display("FAIL %s array_in: got %h want 0", tag, sa_array_in | sa_array_in_partials); else passed++;
    total++; if ({wb_valid, sb_valid, err} !== 3'b000) $display("FAIL %s wb_valid/sb_valid/err: got %b want 000", tag, {wb_valid, sb_valid, err}); else passed++;
    total++; if (sb_vdst !== '0 || wb_wbdst !== '0 || wb_psum !== '0) $display("FAIL %s dst/psum: got %h %h want 0", tag, sb_vdst, wb_wbdst); else passed++;
  endtask

  task automatic test_reset;
    #2;
    check_reset_values("reset");
    step; step;
    nRST = 1;
    step;
  endtask

  task automatic test_act;
    sb_nvalid = 1; sb_nmode = 2'd1; sb_nvdst = 8'd5;
    #1;
    total++; if (sb_ready !== 1'b1) $display("FAIL act_sb_ready: got %b want 1", sb_ready); else passed++;
    step;
    sb_nvalid = 0; veg_valid = 1; veg_vdata = PA;
    #1;
    total++; if (veg_ready !== 1'b1 || sa_input_en !== 1'b0) $display("FAIL act_beat: veg_ready %b input_en %b want 1 0", veg_ready, sa_input_en); else passed++;
    step;
    veg_valid = 0;
    #1;
    total++; if (sa_input_en !== 1'b1 || sa_weight_en !== 1'b0 || sa_partial_en !== 1'b0) $display("FAIL act_strobe: got %b%b%b want 100", sa_input_en, sa_weight_en, sa_partial_en); else passed++;
    total++; if (sa_array_in !== PA) $display("FAIL act_array_in: got %h want %h", sa_array_in, PA); else passed++;
    step;
    total++; if (sa_input_en !== 1'b0 || sb_ready !== 1'b1) $display("FAIL act_after: input_en %b sb_ready %b want 0 1", sa_input_en, sb_ready); else passed++;
    ret(P11);
    #1;
    total++; if (wb_valid !== 1'b1 || wb_wbdst !== 8'd5 || wb_psum !== P11) $display("FAIL act_wb: valid %b dst %0d psum %h want 1 5 %h", wb_valid, wb_wbdst, wb_psum, P11); else passed++;
    total++; if (sb_valid !== 1'b0) $display("FAIL act_no_early_sb_valid: got %b want 0", sb_valid); else passed++;
    wb_output_ready = 1;
    #1;
    total++; if (sb_valid !== 1'b1 || sb_vdst !== 8'd5) $display("FAIL act_sb_valid: got %b %0d want 1 5", sb_valid, sb_vdst); else passed++;
    step;
    wb_output_ready = 0;
    #1;
    total++; if (wb_valid !== 1'b0 || sb_valid !== 1'b0) $display("FAIL act_drained: wb_valid %b sb_valid %b want 0 0", wb_valid, sb_valid); else passed++;
  endtask

  task automatic test_act_psum;
    send(2'd2, 8'd7, PA, PB);
    total++; if (sa_array_in !== PA || sa_array_in_partials !== PB) $display("FAIL psum_data: got %h %h want %h %h", sa_array_in, sa_array_in_partials, PA, PB); else passed++;
    total++; if ({sa_input_en, sa_partial_en, sa_weight_en} !== 3'b110) $display("FAIL psum_strobes: got %b want 110", {sa_input_en, sa_partial_en, sa_weight_en}); else passed++;
    step;
    ret(PB);
    #1;
    total++; if (wb_wbdst !== 8'd7) $display("FAIL psum_wbdst: got %0d want 7", wb_wbdst); else passed++;
    drain;
  endtask

  task automatic test_credit;
    for (int t = 1; t <= 4; t++) begin send(2'd1, TW'(t), DW'(t), '0); step; end
    send(2'd1, 8'd5, PC, '0);
    total++; if (sa_input_en !== 1'b0) $display("FAIL credit_block: input_en got %b want 0", sa_input_en); else passed++;
    step; step;
    total++; if (sa_input_en !== 1'b0) $display("FAIL credit_hold: input_en got %b want 0", sa_input_en); else passed++;
    for (int t = 1; t <= 4; t++) ret(DW'(t * 16));
    wb_output_ready = 1;
    for (int k = 1; k <= 4; k++) begin
      #1;
      total++; if (wb_wbdst !== TW'(k) || sb_vdst !== TW'(k) || wb_psum !== DW'(k * 16)) $display("FAIL credit_order_%0d: dst %0d vdst %0d want %0d", k, wb_wbdst, sb_vdst, k); else passed++;
      if (k == 1) begin total++; if (sa_input_en !== 1'b0) $display("FAIL credit_pop_cycle: input_en got %b want 0", sa_input_en); else passed++; end
      if (k == 2) begin total++; if (sa_input_en !== 1'b1) $display("FAIL credit_release: input_en got %b want 1", sa_input_en); else passed++; end
      step;
    end
    wb_output_ready = 0;
    ret(PC);
    #1;
    total++; if (wb_wbdst !== 8'd5 || wb_psum !== PC) $display("FAIL credit_fifth: dst %0d want 5", wb_wbdst); else passed++;
    drain;
  endtask

  task automatic test_weight;
    send(2'd1, 8'd8, PA, '0); step;
    send(2'd1, 8'd9, PB, '0); step;
    send(2'd0, 8'd0, PC, '0);
    total++; if (sa_weight_en !== 1'b0) $display("FAIL weight_barrier: got %b want 0", sa_weight_en); else passed++;
    step;
    ret(PA);
    ret(PB);
    #1;
    total++; if (sa_weight_en !== 1'b0) $display("FAIL weight_buffered: got %b want 0", sa_weight_en); else passed++;
    wb_output_ready = 1;
    #1;
    total++; if (wb_wbdst !== 8'd8 || sa_weight_en !== 1'b0) $display("FAIL weight_pop1: dst %0d wen %b want 8 0", wb_wbdst, sa_weight_en); else passed++;
    step;
    total++; if (wb_wbdst !== 8'd9 || sa_weight_en !== 1'b0) $display("FAIL weight_pop2: dst %0d wen %b want 9 0", wb_wbdst, sa_weight_en); else passed++;
    step;
    wb_output_ready = 0;
    #1;
    total++; if (sa_weight_en !== 1'b1 || sa_input_en !== 1'b0 || sa_array_in !== PC) $display("FAIL weight_fire: wen %b ien %b want 1 0", sa_weight_en, sa_input_en); else passed++;
    step;
    total++; if (sa_weight_en !== 1'b0 || sb_ready !== 1'b1) $display("FAIL weight_once: wen %b sb_ready %b want 0 1", sa_weight_en, sb_ready); else passed++;
  endtask

  task automatic test_stall;
    sa_fifo_has_space = 0;
    send(2'd1, 8'd3, PC, '0);
    for (int i = 0; i < 3; i++) begin
      total++; if (sa_input_en !== 1'b0 || sa_array_in !== PC || sb_ready !== 1'b0) $display("FAIL stall_%0d: ien %b sb_ready %b want 0 0", i, sa_input_en, sb_ready); else passed++;
      step;
    end
    sa_fifo_has_space = 1;
    #1;
    total++; if (sa_input_en !== 1'b1) $display("FAIL stall_release: got %b want 1", sa_input_en); else passed++;
    step;
    ret(PA);
    drain;
  endtask

  task automatic test_err_and_reset;
    #1;
    total++; if (err !== 1'b0) $display("FAIL err_clean: got %b want 0", err); else passed++;
    sa_out_en = 1;
    step;
    sa_out_en = 0;
    #1;
    total++; if (err !== 1'b1) $display("FAIL err_set: got %b want 1", err); else passed++;
    step; step; step;
    total++; if (err !== 1'b1) $display("FAIL err_sticky: got %b want 1", err); else passed++;
    sb_nvalid = 1; sb_nmode = 2'd2; sb_nvdst = 8'd9;
    step;
    sb_nvalid = 0; veg_valid = 1; veg_vdata = PA;
    step;
    #1;
    total++; if (veg_ready !== 1'b1 || sa_array_in !== PA) $display("FAIL beat1_reached: veg_ready %b want 1", veg_ready); else passed++;
    nRST = 0;
    #1;
    check_reset_values("midreset");
    veg_valid = 0;
    step;
    nRST = 1;
    step;
    send(2'd3, 8'd6, PB, '0);
    total++; if (err !== 1'b1) $display("FAIL err_rsvd: got %b want 1", err); else passed++;
    total++; if ({sa_input_en, sa_partial_en, sa_weight_en} !== 3'b100) $display("FAIL rsvd_as_act: got %b want 100", {sa_input_en, sa_partial_en, sa_weight_en}); else passed++;
    step;
    ret(PB);
    #1;
    total++; if (wb_wbdst !== 8'd6) $display("FAIL rsvd_wbdst: got %0d want 6", wb_wbdst); else passed++;
    drain;
  endtask

  initial begin
    test_reset;
    test_act;
    test_act_psum;
    test_credit;
    test_weight;
    test_stall;
    test_err_and_reset;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/gsau_ctrl_v2.md
# gsau_ctrl_v2

Parametrised second-generation GSAU control unit. Sits between the scoreboard, the veggie (vector register) file, the systolic array, and the WB buffer. It accepts one instruction at a time and supports three modes: weight load, activation-only, and activation plus partial-sum. It tracks up to DEPTH in-flight results by destination tag and buffers array outputs, because the array cannot be back-pressured.

## Interface
- DATA_W, 512: vector, array I/O and psum width.
- TAG_W, 8: destination register index width.
- DEPTH, 4: maximum in-flight activation ops. Power of two, ≥2.
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- sb_nvalid  in  1  instruction valid.
- sb_nvdst  in  TAG_W  instruction destination.
- sb_nmode  in  2  instruction mode: 0 WEIGHT, 1 ACT, 2 ACT_PSUM, 3 reserved (treated as ACT).
- sb_ready  out  1  instruction accept.
- sb_valid  out  1  completion pulse.
- sb_vdst  out  TAG_W  completed destination.
- veg_vdata  in  DATA_W  vector beat.
- veg_valid  in  1  beat valid.
- veg_ready  out  1  beat accept.
- sa_array_in  out  DATA_W  activations or weights.
- sa_array_in_partials  out  DATA_W  partial sums.
- sa_input_en, sa_weight_en, sa_partial_en  out  1 each  one-cycle issue strobes.
- sa_fifo_has_space  in  1  array can take an issue this cycle.
- sa_array_output  in  DATA_W  result.
- sa_out_en  in  1  result valid, single cycle, no back-pressure.
- wb_psum  out  DATA_W  result to WB buffer.
- wb_wbdst  out  TAG_W  result destination.
- wb_valid  out  1  result valid.
- wb_output_ready  in  1  WB buffer accept.
- err  out  1  sticky protocol error.

## Operation
- Handshakes: a transfer occurs when valid && ready in the same cycle. A producer holds valid and data stable until the transfer.
- FSM state IDLE:
  - sb_ready=1.
  - On sb transfer, latch vdst and mode, then go to BEAT0.
- FSM state BEAT0:
  - veg_ready=1.
  - On transfer, latch beat into act_q.
  - Next state is BEAT1 for ACT_PSUM, otherwise ISSUE.
- FSM state BEAT1:
  - veg_ready=1.
  - On transfer, latch beat into psum_q, then go to ISSUE.
- FSM state ISSUE:
  - sa_array_in=act_q and sa_array_in_partials=psum_q.
  - Fire the strobes when the issue condition holds, then return to IDLE. Otherwise hold in ISSUE.
  - WEIGHT issue condition: sa_fifo_has_space && inflight==0 (weight barrier: all prior results drained to WB). Asserts sa_weight_en.
  - ACT issue condition: sa_fifo_has_space && inflight<DEPTH. Asserts sa_input_en.
  - ACT_PSUM issue condition: same as ACT. Asserts sa_input_en and sa_partial_en.
  - On an ACT or ACT_PSUM issue, push vdst into the tag FIFO.
- inflight counter (width log2(DEPTH)+1):
  - +1 on ACT or ACT_PSUM issue.
  - −1 on WB transfer.
  - Both events in the same cycle leave it unchanged.
- On sa_out_en:
  - Pop the tag FIFO.
  - Push {tag, sa_array_output} into the result FIFO (depth DEPTH).
  - Capacity cannot be exceeded because of the credit rule.
- WB side:
  - wb_valid = result FIFO not empty; wb_psum and wb_wbdst come from the FIFO head.
  - On WB transfer, pop the FIFO and pulse sb_valid with sb_vdst = the popped tag in the same cycle.
- err is set and held until reset when:
  - sa_out_en arrives with the tag FIFO empty, or
  - sb_nmode==3 is accepted.
- Results return in issue order. Tags are not reordered.

## Timing
- Reset values: FSM=IDLE, sb_ready=1, veg_ready=0, all sa_*_en=0, sa_array_in=0, sa_array_in_partials=0, wb_valid=0, sb_valid=0, sb_vdst=0, wb_psum=0, wb_wbdst=0, err=0, inflight=0, FIFOs empty.
- Latency with no stalls: sb transfer in cycle N, veg beat in N+1, strobe in N+2. ACT_PSUM adds one cycle.
- Earliest next sb accept after an issue: the cycle after the strobe (IDLE).
- sa_out_en in cycle M gives wb_valid=1 in M+1. A simultaneous sa_out_en push and WB pop are both honoured.
- FIFO pointers are log2(DEPTH)+1 bits, with a wrap bit for full/empty.
- A reset mid-operation discards the latched instruction, in-flight tags and buffered results.

## Structure
- Shared package (sys_arr_pkg) holds:
  - gsau_mode_t enum {WEIGHT, ACT, ACT_PSUM, RSVD}.
  - gsau_state_t {IDLE, BEAT0, BEAT1, ISSUE}.
  - Default DATA_W, TAG_W and DEPTH constants.
- One sub-module, gsau_sync_fifo (params WIDTH, DEPTH): push, pop, full, empty, head. It is instantiated twice: as the tag FIFO (TAG_W) and the result FIFO (TAG_W+DATA_W).

## Test plan
- ACT with vdst=5 and beat=0xAA..: sa_input_en for one cycle at N+2. Then sa_out_en with 0x11..: wb_valid with wbdst=5 and psum=0x11..; on wb_output_ready, sb_valid pulses with sb_vdst=5.
- ACT_PSUM with two beats A and B: at issue, sa_array_in=A, sa_array_in_partials=B, sa_input_en=sa_partial_en=1, sa_weight_en=0.
- Four ACTs (tags 1-4) with wb_output_ready=0: a fifth ACT holds in ISSUE. Return four results: the WB order is 1,2,3,4 and the fifth issues after the first WB pop.
- WEIGHT behind two in-flight ACTs: no sa_weight_en until both are drained through WB. It then fires once.
- sa_fifo_has_space=0 for 3 cycles in ISSUE: no strobes and outputs stable; the strobe follows on the cycle space returns.
- sa_out_en with nothing in flight: err=1 and stays 1; nRST low mid-BEAT1 gives all reset values.
